// File: rtl/pipeline_pkg.sv
// Shared MIPS pipeline definitions: fetch constants, PCSrc encodings and the IF state enum.
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] RESET_PC   = 32'h0040_0000;
  localparam logic [31:0] EXC_VECTOR = 32'h8000_0180;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_J   = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;

  typedef enum logic {
    RUN = 1'b0,
    BUF = 1'b1
  } state_e;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request port between the fetch stage (master) and memory (slave).
// Handshake: a word moves on a rising edge where imem_req && imem_ready; imem_rdata is valid
// in that same cycle, and imem_addr holds steady while imem_req is high and imem_ready is low.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/if_stage_pc_next_sel.sv
// Redirect decision for the fetch stage: whether ID redirects the PC and where to.
module pc_next_sel
  import pipeline_pkg::*;
(
  input  logic        i_stall,
  input  logic [1:0]  i_jump,
  input  logic        i_branch,
  input  logic        i_branch_cond,
  input  logic [31:0] i_jump_target,
  input  logic [31:0] i_jr_target,
  output logic        o_redir,
  output logic [31:0] o_target
);

  // A stalled ID may hold a stale control word, so its redirect waits for the stall to end.
  assign o_redir  = ~i_stall & ((i_jump != PCSRC_SEQ) | (i_branch & i_branch_cond));
  assign o_target = (i_jump == PCSRC_JR) ? i_jr_target : i_jump_target;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage with IF/ID register and one-word stall buffer.
// Optional interrupt entry (irq/irq_ack/EPC) is enabled by defining IF_IRQ_EN.
module if_stage #(
  parameter logic [31:0] RESET_PC = pipeline_pkg::RESET_PC
`ifdef IF_IRQ_EN
  , parameter logic [31:0] EXC_VECTOR = pipeline_pkg::EXC_VECTOR
`endif
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Stall,
  input  logic [1:0]            Jump,
  input  logic                  Branch,
  input  logic                  BranchCond,
  input  logic [31:0]           JumpTarget,
  input  logic [31:0]           JrTarget,
  if_stage_if.master            imem,
  output logic [31:0]           IFID_Instruction,
  output logic [31:0]           IFID_PC,
  output logic                  IFID_Valid,
`ifdef IF_IRQ_EN
  input  logic                  irq,
  output logic                  irq_ack,
  output logic [31:0]           EPC,
`endif
  output pipeline_pkg::state_e  o_dbg_state
);
  import pipeline_pkg::*;

  state_e      r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_buf_instr, w_buf_instr_nxt;
  logic [31:0] r_buf_pc, w_buf_pc_nxt;
  logic [31:0] r_ifid_instr, w_ifid_instr_nxt;
  logic [31:0] r_ifid_pc, w_ifid_pc_nxt;
  logic        r_ifid_valid, w_ifid_valid_nxt;
  logic        w_redir, w_xfer, w_req, w_irq_take;
  logic [31:0] w_target;

  pc_next_sel u_pc_next_sel (
    .i_stall       (Stall),
    .i_jump        (Jump),
    .i_branch      (Branch),
    .i_branch_cond (BranchCond),
    .i_jump_target (JumpTarget),
    .i_jr_target   (JrTarget),
    .o_redir       (w_redir),
    .o_target      (w_target)
  );

  assign w_xfer = w_req & imem.imem_ready;

`ifdef IF_IRQ_EN
  logic [31:0] r_epc;

  assign w_irq_take = (r_state == RUN) & ~Stall & ~w_redir & irq;
  assign irq_ack    = w_irq_take;
  assign EPC        = r_epc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          r_epc <= 32'h0;
    else if (w_irq_take) r_epc <= r_pc;
  end
`else
  assign w_irq_take = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= RUN;
      r_pc         <= RESET_PC;
      r_buf_instr  <= NOP_INSTR;
      r_buf_pc     <= 32'h0;
      r_ifid_instr <= NOP_INSTR;
      r_ifid_pc    <= 32'h0;
      r_ifid_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_buf_instr  <= w_buf_instr_nxt;
      r_buf_pc     <= w_buf_pc_nxt;
      r_ifid_instr <= w_ifid_instr_nxt;
      r_ifid_pc    <= w_ifid_pc_nxt;
      r_ifid_valid <= w_ifid_valid_nxt;
    end
  end

  // Decision order within each state matters: redirect beats interrupt beats stall beats fetch.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_buf_instr_nxt  = r_buf_instr;
    w_buf_pc_nxt     = r_buf_pc;
    w_ifid_instr_nxt = r_ifid_instr;
    w_ifid_pc_nxt    = r_ifid_pc;
    w_ifid_valid_nxt = r_ifid_valid;
    case (r_state)
      RUN: begin
        if (w_redir) begin
          w_pc_nxt         = w_target;
          w_ifid_instr_nxt = NOP_INSTR;
          w_ifid_valid_nxt = 1'b0;
        end else if (w_irq_take) begin
`ifdef IF_IRQ_EN
          w_pc_nxt         = EXC_VECTOR;
`endif
          w_ifid_instr_nxt = NOP_INSTR;
          w_ifid_valid_nxt = 1'b0;
        end else if (Stall) begin
          if (w_xfer) begin
            w_buf_instr_nxt = imem.imem_rdata;
            w_buf_pc_nxt    = r_pc;
            w_pc_nxt        = r_pc + 32'd4;
            w_state_nxt     = BUF;
          end
        end else if (w_xfer) begin
          w_ifid_instr_nxt = imem.imem_rdata;
          w_ifid_pc_nxt    = r_pc;
          w_ifid_valid_nxt = 1'b1;
          w_pc_nxt         = r_pc + 32'd4;
        end else begin
          w_ifid_instr_nxt = NOP_INSTR;
          w_ifid_valid_nxt = 1'b0;
        end
      end
      BUF: begin
        if (w_redir) begin
          w_pc_nxt         = w_target;
          w_ifid_instr_nxt = NOP_INSTR;
          w_ifid_valid_nxt = 1'b0;
          w_state_nxt      = RUN;
        end else if (!Stall) begin
          w_ifid_instr_nxt = r_buf_instr;
          w_ifid_pc_nxt    = r_buf_pc;
          w_ifid_valid_nxt = 1'b1;
          w_state_nxt      = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // The buffered state must not fetch again; reset also silences the request.
  always_comb begin
    w_req          = reset & (r_state == RUN);
    imem.imem_req  = w_req;
    imem.imem_addr = r_pc;
  end

  assign IFID_Instruction = r_ifid_instr;
  assign IFID_PC          = r_ifid_pc;
  assign IFID_Valid       = r_ifid_valid;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed scenarios plus randomized traffic against a fetch-stream model.
module tb_if_stage;
  import pipeline_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        Stall, Branch, BranchCond;
  logic [1:0]  Jump;
  logic [31:0] JumpTarget, JrTarget;
  logic [31:0] IFID_Instruction, IFID_PC;
  logic        IFID_Valid;
  state_e      dbg_state;
`ifdef IF_IRQ_EN
  logic        irq = 1'b0;
  logic        irq_ack;
  logic [31:0] EPC;
  logic        ack_seen;
`endif

  if_stage_if imem ();
  assign imem.imem_rdata = imem.imem_addr ^ 32'hA5A5_0000;

  if_stage dut (
    .clk              (clk),
    .reset            (reset),
    .Stall            (Stall),
    .Jump             (Jump),
    .Branch           (Branch),
    .BranchCond       (BranchCond),
    .JumpTarget       (JumpTarget),
    .JrTarget         (JrTarget),
    .imem             (imem),
    .IFID_Instruction (IFID_Instruction),
    .IFID_PC          (IFID_PC),
    .IFID_Valid       (IFID_Valid),
`ifdef IF_IRQ_EN
    .irq              (irq),
    .irq_ack          (irq_ack),
    .EPC              (EPC),
`endif
    .o_dbg_state      (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  // The fetch stream: next address to fetch, fetched-but-not-delivered words, expected IF/ID.
  logic [31:0] m_pc;
  logic [31:0] exp_q[$];
  logic [31:0] e_instr, e_pc, m_epc;
  logic        e_valid, e_ack;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic void model_reset();
    m_pc    = 32'h0040_0000;
    exp_q.delete();
    e_instr = 32'h0;
    e_pc    = 32'h0;
    e_valid = 1'b0;
    m_epc   = 32'h0;
    e_ack   = 1'b0;
  endfunction

  function automatic void bubble();
    e_instr = 32'h0;
    e_valid = 1'b0;
  endfunction

  function automatic void model_edge();
    logic        redir;
    logic [31:0] tgt;
    redir = !Stall && (Jump != 2'b00 || (Branch && BranchCond));
    tgt   = (Jump == 2'b10) ? JrTarget : JumpTarget;
    e_ack = 1'b0;
    if (exp_q.size() == 0) begin
      if (redir) begin
        m_pc = tgt; bubble();
`ifdef IF_IRQ_EN
      end else if (!Stall && irq) begin
        e_ack = 1'b1; m_epc = m_pc; m_pc = 32'h8000_0180; bubble();
`endif
      end else if (Stall) begin
        if (imem.imem_ready) begin exp_q.push_back(m_pc); m_pc = m_pc + 32'd4; end
      end else if (imem.imem_ready) begin
        e_pc = m_pc; e_instr = mem_word(m_pc); e_valid = 1'b1; m_pc = m_pc + 32'd4;
      end else begin
        bubble();
      end
    end else begin
      if (redir) begin
        exp_q.delete(); m_pc = tgt; bubble();
      end else if (!Stall) begin
        e_pc = exp_q.pop_front(); e_instr = mem_word(e_pc); e_valid = 1'b1;
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic s, input logic [1:0] j, input logic b, input logic c,
                        input logic [31:0] jt, input logic [31:0] jrt, input logic rdy);
    Stall = s; Jump = j; Branch = b; BranchCond = c;
    JumpTarget = jt; JrTarget = jrt; imem.imem_ready = rdy;
  endtask

  // Called at a negedge with inputs applied; returns at the following negedge.
  task automatic tick();
    model_edge();
    #1;
`ifdef IF_IRQ_EN
    ack_seen = irq_ack;
`endif
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    set_in(0, 2'b00, 0, 0, 32'h0, 32'h0, 1);
    model_reset();
    repeat (2) @(negedge clk);
    n_tests++; if (IFID_Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", IFID_Valid); end
    n_tests++; if (IFID_Instruction !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 0", IFID_Instruction); end
    n_tests++; if (IFID_PC !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", IFID_PC); end
    n_tests++; if (imem.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem.imem_req); end
    n_tests++; if (imem.imem_addr !== 32'h0040_0000) begin n_fail++; $display("FAIL reset_addr: got %h expected 00400000", imem.imem_addr); end
    reset = 1'b1;
    #1;
    n_tests++; if (imem.imem_req !== 1'b1) begin n_fail++; $display("FAIL release_req: got %b expected 1", imem.imem_req); end
  endtask

  task automatic test_sequential();
    logic [31:0] pcs [3];
    pcs[0] = 32'h0040_0000; pcs[1] = 32'h0040_0004; pcs[2] = 32'h0040_0008;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (IFID_Valid !== 1'b1 || IFID_PC !== pcs[i] || IFID_Instruction !== (pcs[i] ^ 32'hA5A5_0000)) begin
        n_fail++; $display("FAIL seq_%0d: got v=%b pc=%h ins=%h expected v=1 pc=%h", i, IFID_Valid, IFID_PC, IFID_Instruction, pcs[i]);
      end
    end
  endtask

  task automatic test_stall_buffer();
    logic [31:0] held_pc, prev_pc;
    held_pc = m_pc; prev_pc = IFID_PC;
    set_in(1, 2'b00, 0, 0, 32'h0, 32'h0, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (imem.imem_req !== 1'b0 || IFID_PC !== prev_pc || exp_q.size() != 1) begin
        n_fail++; $display("FAIL stall_%0d: got req=%b pc=%h expected req=0 pc=%h", i, imem.imem_req, IFID_PC, prev_pc);
      end
    end
    set_in(0, 2'b00, 0, 0, 32'h0, 32'h0, 1);
    tick();
    n_tests++; if (IFID_Valid !== 1'b1 || IFID_PC !== held_pc) begin n_fail++; $display("FAIL unstall_buf: got v=%b pc=%h expected v=1 pc=%h", IFID_Valid, IFID_PC, held_pc); end
    tick();
    n_tests++; if (IFID_Valid !== 1'b1 || IFID_PC !== held_pc + 32'd4) begin n_fail++; $display("FAIL unstall_next: got v=%b pc=%h expected v=1 pc=%h", IFID_Valid, IFID_PC, held_pc + 32'd4); end
  endtask

  task automatic test_jump();
    logic [31:0] tg [3];
    logic [1:0]  js [3];
    tg[0] = 32'h0040_0100; tg[1] = 32'h0040_0200; tg[2] = 32'hFFFF_FFFC;
    js[0] = 2'b01;         js[1] = 2'b10;         js[2] = 2'b01;
    for (int i = 0; i < 3; i++) begin
      set_in(0, js[i], 0, 0, (js[i] == 2'b01) ? tg[i] : 32'h0BAD_0000, (js[i] == 2'b10) ? tg[i] : 32'h0BAD_0000, 1);
      tick();
      n_tests++; if (IFID_Valid !== 1'b0 || IFID_Instruction !== 32'h0 || imem.imem_addr !== tg[i]) begin
        n_fail++; $display("FAIL jump_bubble_%0d: got v=%b ins=%h addr=%h expected v=0 ins=0 addr=%h", i, IFID_Valid, IFID_Instruction, imem.imem_addr, tg[i]);
      end
      set_in(0, 2'b00, 0, 0, 32'h0, 32'h0, 1);
      tick();
      n_tests++; if (IFID_Valid !== 1'b1 || IFID_PC !== tg[i]) begin
        n_fail++; $display("FAIL jump_target_%0d: got v=%b pc=%h expected v=1 pc=%h", i, IFID_Valid, IFID_PC, tg[i]);
      end
    end
    tick();
    n_tests++; if (IFID_PC !== 32'h0) begin n_fail++; $display("FAIL pc_wrap: got %h expected 00000000", IFID_PC); end
  endtask

  task automatic test_branch();
    logic [31:0] seq_pc;
    set_in(0, 2'b00, 1, 1, 32'h0040_0300, 32'h0, 1);
    tick();
    n_tests++; if (IFID_Valid !== 1'b0 || imem.imem_addr !== 32'h0040_0300) begin n_fail++; $display("FAIL br_taken: got v=%b addr=%h expected v=0 addr=00400300", IFID_Valid, imem.imem_addr); end
    seq_pc = m_pc;
    set_in(0, 2'b00, 1, 0, 32'h0040_0400, 32'h0, 1);
    tick();
    n_tests++; if (IFID_Valid !== 1'b1 || IFID_PC !== 32'h0040_0300 || imem.imem_addr !== seq_pc + 32'd4) begin
      n_fail++; $display("FAIL br_not_taken: got v=%b pc=%h addr=%h expected v=1 pc=00400300 addr=%h", IFID_Valid, IFID_PC, imem.imem_addr, seq_pc + 32'd4);
    end
    seq_pc = m_pc;
    set_in(1, 2'b01, 0, 0, 32'h0040_0500, 32'h0, 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++; if (imem.imem_addr !== seq_pc + 32'd4 || imem.imem_req !== 1'b0) begin
        n_fail++; $display("FAIL stall_redirect_%0d: got addr=%h req=%b expected addr=%h req=0", i, imem.imem_addr, imem.imem_req, seq_pc + 32'd4);
      end
    end
    set_in(0, 2'b01, 0, 0, 32'h0040_0500, 32'h0, 1);
    tick();
    n_tests++; if (IFID_Valid !== 1'b0 || imem.imem_addr !== 32'h0040_0500 || imem.imem_req !== 1'b1) begin
      n_fail++; $display("FAIL redirect_after_stall: got v=%b addr=%h req=%b expected v=0 addr=00400500 req=1", IFID_Valid, imem.imem_addr, imem.imem_req);
    end
    set_in(0, 2'b00, 0, 0, 32'h0, 32'h0, 1);
    tick();
    n_tests++; if (IFID_Valid !== 1'b1 || IFID_PC !== 32'h0040_0500) begin n_fail++; $display("FAIL redirect_fetch: got v=%b pc=%h expected v=1 pc=00400500", IFID_Valid, IFID_PC); end
  endtask

  task automatic test_mem_wait();
    logic [31:0] a0;
    a0 = m_pc;
    set_in(0, 2'b00, 0, 0, 32'h0, 32'h0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++; if (IFID_Valid !== 1'b0 || IFID_Instruction !== 32'h0 || imem.imem_addr !== a0 || imem.imem_req !== 1'b1) begin
        n_fail++; $display("FAIL wait_%0d: got v=%b addr=%h req=%b expected v=0 addr=%h req=1", i, IFID_Valid, imem.imem_addr, imem.imem_req, a0);
      end
    end
    imem.imem_ready = 1'b1;
    tick();
    n_tests++; if (IFID_Valid !== 1'b1 || IFID_PC !== a0) begin n_fail++; $display("FAIL wait_done: got v=%b pc=%h expected v=1 pc=%h", IFID_Valid, IFID_PC, a0); end
  endtask

  task automatic test_reset_midwait();
    set_in(0, 2'b00, 0, 0, 32'h0, 32'h0, 0);
    tick();
    #2 reset = 1'b0;
    #1;
    n_tests++; if (IFID_Valid !== 1'b0 || IFID_Instruction !== 32'h0 || IFID_PC !== 32'h0) begin
      n_fail++; $display("FAIL async_reset_ifid: got v=%b ins=%h pc=%h expected all 0", IFID_Valid, IFID_Instruction, IFID_PC);
    end
    n_tests++; if (imem.imem_addr !== 32'h0040_0000 || imem.imem_req !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_pc: got addr=%h req=%b expected addr=00400000 req=0", imem.imem_addr, imem.imem_req);
    end
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    imem.imem_ready = 1'b1;
    tick();
    n_tests++; if (IFID_Valid !== 1'b1 || IFID_PC !== 32'h0040_0000) begin n_fail++; $display("FAIL reset_refetch: got v=%b pc=%h expected v=1 pc=00400000", IFID_Valid, IFID_PC); end
  endtask

`ifdef IF_IRQ_EN
  task automatic test_irq();
    set_in(0, 2'b01, 0, 0, 32'h0040_0010, 32'h0, 1);
    tick();
    set_in(0, 2'b00, 0, 0, 32'h0, 32'h0, 1);
    irq = 1'b1;
    tick();
    irq = 1'b0;
    n_tests++; if (ack_seen !== 1'b1 || EPC !== 32'h0040_0010 || imem.imem_addr !== 32'h8000_0180 || IFID_Valid !== 1'b0) begin
      n_fail++; $display("FAIL irq_take: got ack=%b epc=%h addr=%h v=%b expected ack=1 epc=00400010 addr=80000180 v=0", ack_seen, EPC, imem.imem_addr, IFID_Valid);
    end
    tick();
    n_tests++; if (ack_seen !== 1'b0 || IFID_PC !== 32'h8000_0180 || IFID_Valid !== 1'b1) begin
      n_fail++; $display("FAIL irq_vector: got ack=%b pc=%h v=%b expected ack=0 pc=80000180 v=1", ack_seen, IFID_PC, IFID_Valid);
    end
    set_in(0, 2'b01, 0, 0, 32'h0040_0600, 32'h0, 1);
    irq = 1'b1;
    tick();
    irq = 1'b0;
    n_tests++; if (ack_seen !== 1'b0 || imem.imem_addr !== 32'h0040_0600 || EPC !== 32'h0040_0010) begin
      n_fail++; $display("FAIL irq_vs_jump: got ack=%b addr=%h epc=%h expected ack=0 addr=00400600 epc=00400010", ack_seen, imem.imem_addr, EPC);
    end
  endtask
`endif

  task automatic test_random();
    int unsigned r;
    logic [1:0]  j;
    logic [31:0] jt, jrt;
    for (int i = 0; i < 400; i++) begin
      r  = $urandom_range(0, 99);
      j  = (r < 8) ? 2'b01 : (r < 12) ? 2'b10 : 2'b00;
      jt  = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8 : (32'h0040_0000 | ($urandom_range(0, 32'h3FFF) << 2));
      jrt = 32'h0040_0000 | ($urandom_range(0, 32'h3FFF) << 2);
      set_in($urandom_range(0, 3) == 0, j, $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
             jt, jrt, $urandom_range(0, 9) < 7);
`ifdef IF_IRQ_EN
      irq = ($urandom_range(0, 19) == 0);
`endif
      tick();
      n_tests++;
      if (IFID_Valid !== e_valid || (e_valid && (IFID_PC !== e_pc || IFID_Instruction !== e_instr)) ||
          (!e_valid && IFID_Instruction !== 32'h0)) begin
        n_fail++; $display("FAIL rand_ifid_%0d: got v=%b pc=%h ins=%h expected v=%b pc=%h ins=%h", i, IFID_Valid, IFID_PC, IFID_Instruction, e_valid, e_pc, e_instr);
      end
      n_tests++;
      if (imem.imem_req !== (exp_q.size() == 0) || imem.imem_addr !== m_pc) begin
        n_fail++; $display("FAIL rand_imem_%0d: got req=%b addr=%h expected req=%b addr=%h", i, imem.imem_req, imem.imem_addr, exp_q.size() == 0, m_pc);
      end
`ifdef IF_IRQ_EN
      n_tests++;
      if (ack_seen !== e_ack || EPC !== m_epc) begin
        n_fail++; $display("FAIL rand_irq_%0d: got ack=%b epc=%h expected ack=%b epc=%h", i, ack_seen, EPC, e_ack, m_epc);
      end
`endif
    end
`ifdef IF_IRQ_EN
    irq = 1'b0;
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_sequential();
    test_stall_buffer();
    test_jump();
    test_branch();
    test_mem_wait();
    test_reset_midwait();
`ifdef IF_IRQ_EN
    test_irq();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
